// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the telemetry frame scheduler.
package uart_frame_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int DEF_N_CH   = 6;
   localparam int DEF_DATA_W = 12;
   localparam int DEF_TAG_W  = 4;

   function automatic int frame_w(input int tag_w, input int data_w);
      return tag_w + data_w;
   endfunction

endpackage

// File: rtl/uart_frame_sched_rr_arbiter.sv
// Channel selector: channel 0 always wins, channels 1..N_CH-1 rotate after the pointer.
module rr_arbiter #(
   parameter int N_CH  = 6,
   parameter int PTR_W = 3
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [PTR_W-1:0] gnt_o,
   output logic             gnt_valid_o
);

   logic [N_CH-1:0] upper_req;

   always_comb begin
      upper_req   = '0;
      gnt_o       = '0;
      gnt_valid_o = |req_i;
      for (int i = 1; i < N_CH; i++) begin
         upper_req[i] = req_i[i] && (PTR_W'(i) > ptr_i);
      end
      if (!req_i[0]) begin
         // Lowest requester overall is the wrap-around fallback; a requester above the pointer overrides it.
         for (int i = N_CH - 1; i >= 1; i--) begin
            if (req_i[i]) gnt_o = PTR_W'(i);
         end
         for (int i = N_CH - 1; i >= 1; i--) begin
            if (upper_req[i]) gnt_o = PTR_W'(i);
         end
      end
   end

endmodule

// File: rtl/uart_frame_sched.sv
// Change-driven telemetry frame scheduler: sends {channel, payload} whenever a
// channel differs from its last-sent copy, with a channel-0 keepalive.
module uart_frame_sched
   import uart_frame_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int TAG_W         = DEF_TAG_W,
   parameter int KEEPALIVE_CYC = 1000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [N_CH*DATA_W-1:0]  ch_data,
   input  logic                    frame_ready,
   output logic                    frame_valid,
   output logic [TAG_W+DATA_W-1:0] frame_data
);

   localparam int FRAME_W            = frame_w(TAG_W, DATA_W);
   localparam int PTR_W              = $clog2(N_CH);
   localparam int KA_W               = (KEEPALIVE_CYC > 1) ? $clog2(KEEPALIVE_CYC) : 1;
   localparam bit KA_EN              = (KEEPALIVE_CYC != 0);
   localparam logic [KA_W-1:0] KA_LAST = KA_W'(KEEPALIVE_CYC - 1);

   if (N_CH < 2 || N_CH > 16 || N_CH > (1 << TAG_W)) begin : g_bad_cfg
      $error("uart_frame_sched: N_CH must be 2..16 and representable in TAG_W bits");
   end

   state_e             state_q;
   logic               frame_valid_q;
   logic [FRAME_W-1:0] frame_data_q;
   logic [DATA_W-1:0]  shadow_q [N_CH];
   logic [N_CH-1:0]    force_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [KA_W-1:0]    ka_cnt_q;

   logic [N_CH-1:0]    pending_d;
   logic [PTR_W-1:0]   gnt_idx_d;
   logic               gnt_vld_d;
   logic [DATA_W-1:0]  gnt_data_d;
   logic               grant_d;

   always_comb begin
      pending_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         pending_d[i] = (ch_data[i*DATA_W +: DATA_W] != shadow_q[i]) || force_q[i];
      end
   end

   rr_arbiter #(
      .N_CH  (N_CH),
      .PTR_W (PTR_W)
   ) u_arb (
      .req_i       (pending_d),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt_idx_d),
      .gnt_valid_o (gnt_vld_d)
   );

   // Payload is captured from the live input at grant time, so repeated changes collapse into one frame.
   assign gnt_data_d = ch_data[int'(gnt_idx_d)*DATA_W +: DATA_W];
   assign grant_d    = (state_q == IDLE) && en && gnt_vld_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         frame_valid_q <= 1'b0;
         frame_data_q  <= '0;
         for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
         force_q       <= '1;
         ptr_q         <= '0;
         ka_cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  frame_data_q          <= {TAG_W'(gnt_idx_d), gnt_data_d};
                  shadow_q[gnt_idx_d]   <= gnt_data_d;
                  force_q[gnt_idx_d]    <= 1'b0;
                  if (gnt_idx_d != '0) ptr_q <= gnt_idx_d;
                  ka_cnt_q              <= '0;
                  frame_valid_q         <= 1'b1;
                  state_q               <= SEND;
               end else if (KA_EN && en && !(|pending_d)) begin
                  if (ka_cnt_q == KA_LAST) begin
                     ka_cnt_q   <= '0;
                     force_q[0] <= 1'b1;
                  end else begin
                     ka_cnt_q <= ka_cnt_q + KA_W'(1);
                  end
               end
            end
            SEND: begin
               if (frame_ready) begin
                  frame_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign frame_valid = frame_valid_q;
   assign frame_data  = frame_data_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed scenarios plus random traffic against a behavioural model of the scheduler.
module tb_uart_frame_sched;

   localparam int N_CH   = 6;
   localparam int DATA_W = 12;
   localparam int TAG_W  = 4;
   localparam int KA     = 8;
   localparam int FW     = TAG_W + DATA_W;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   en;
   logic [N_CH*DATA_W-1:0] ch_data;
   logic                   frame_ready;
   logic                   frame_valid;
   logic [FW-1:0]          frame_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_frame_sched #(
      .N_CH          (N_CH),
      .DATA_W        (DATA_W),
      .TAG_W         (TAG_W),
      .KEEPALIVE_CYC (KA)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .ch_data     (ch_data),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_data  (frame_data)
   );

   // Reference model: last-sent copies, forced channels, busy flag, idle-cycle count.
   logic [DATA_W-1:0] m_shadow [N_CH];
   bit                m_force  [N_CH];
   bit                m_busy;
   bit                m_fv;
   logic [FW-1:0]     m_fd;
   int                m_last;
   int                m_idle;

   function automatic logic [DATA_W-1:0] chv(input int i);
      return ch_data[i*DATA_W +: DATA_W];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_shadow[i] = '0;
         m_force[i]  = 1'b1;
      end
      m_busy = 1'b0;
      m_fv   = 1'b0;
      m_fd   = '0;
      m_last = 0;
      m_idle = 0;
   endfunction

   function automatic void model_step();
      bit pend [N_CH];
      bit any;
      int g;
      any = 1'b0;
      g   = -1;
      for (int i = 0; i < N_CH; i++) begin
         pend[i] = (chv(i) != m_shadow[i]) || m_force[i];
         any     = any | pend[i];
      end
      if (m_busy) begin
         if (frame_ready) begin
            m_busy = 1'b0;
            m_fv   = 1'b0;
         end
         return;
      end
      if (!en) return;
      if (!any) begin
         m_idle++;
         if (m_idle == KA) begin
            m_force[0] = 1'b1;
            m_idle     = 0;
         end
         return;
      end
      if (pend[0]) g = 0;
      else begin
         for (int k = 1; k < N_CH; k++) begin
            int c;
            c = ((m_last - 1 + k) % (N_CH - 1)) + 1;
            if (pend[c] && g < 0) g = c;
         end
      end
      m_fd        = {TAG_W'(g), chv(g)};
      m_shadow[g] = chv(g);
      m_force[g]  = 1'b0;
      if (g != 0) m_last = g;
      m_idle = 0;
      m_busy = 1'b1;
      m_fv   = 1'b1;
   endfunction

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic setch(input int i, input logic [DATA_W-1:0] v);
      ch_data[i*DATA_W +: DATA_W] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk_b("model_valid", frame_valid, m_fv);
      chk_w("model_data", frame_data, m_fd);
   endtask

   task automatic wait_frame(input string tag, output logic [FW-1:0] d, output int k);
      k = 0;
      do begin
         tick();
         k++;
      end while (!frame_valid && k < 40);
      chk_b({tag, "_arrive"}, frame_valid, 1'b1);
      d = frame_data;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_b("rst_valid", frame_valid, 1'b0);
      chk_w("rst_data", frame_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic startup_seq(input string tag);
      for (int i = 0; i < N_CH; i++) begin
         tick();
         chk_b({tag, "_valid"}, frame_valid, 1'b1);
         chk_w({tag, "_frame"}, frame_data, {TAG_W'(i), chv(i)});
         tick();
         chk_b({tag, "_gap"}, frame_valid, 1'b0);
      end
   endtask

   initial begin
      logic [FW-1:0] d;
      int            k;
      int            extra;

      rst_n       = 1'b0;
      en          = 1'b1;
      frame_ready = 1'b1;
      ch_data     = '0;
      model_reset();
      #1;
      chk_b("rst_valid", frame_valid, 1'b0);
      chk_w("rst_data", frame_data, '0);
      @(negedge clk);
      rst_n = 1'b1;

      startup_seq("startup");

      // Single change on channel 3
      setch(3, 12'h5A5);
      wait_frame("ch3", d, k);
      chk_w("ch3_frame", d, 16'h35A5);
      extra = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (frame_valid && frame_data[FW-1 -: TAG_W] != '0) extra++;
      end
      chk_i("ch3_once", extra, 0);
      for (int c = 0; c < 3 && frame_valid; c++) tick();

      // Simultaneous change: channel 0 takes priority
      setch(0, 12'h123);
      setch(2, 12'hABC);
      wait_frame("prio0", d, k);
      chk_w("prio0_frame", d, 16'h0123);
      wait_frame("prio2", d, k);
      chk_w("prio2_frame", d, 16'h2ABC);
      tick();

      // Back-pressure with data changing under the held frame
      frame_ready = 1'b0;
      setch(4, 12'h001);
      wait_frame("hold", d, k);
      chk_w("hold_first", d, 16'h4001);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) setch(4, 12'h002);
         tick();
         chk_b("hold_valid", frame_valid, 1'b1);
         chk_w("hold_data", frame_data, 16'h4001);
      end
      frame_ready = 1'b1;
      tick();
      wait_frame("resend", d, k);
      chk_w("resend_frame", d, 16'h4002);
      chk_i("resend_lat", k, 1);
      tick();

      // Keepalive: KA idle cycles, then one grant cycle
      wait_frame("ka1", d, k);
      chk_i("ka1_gap", k, KA + 1);
      chk_w("ka1_frame", d, 16'h0123);
      tick();
      wait_frame("ka2", d, k);
      chk_i("ka2_gap", k, KA + 1);
      tick();

      en    = 1'b0;
      extra = 0;
      for (int c = 0; c < 30; c++) begin
         if (c == 5) setch(1, 12'h777);
         tick();
         if (frame_valid) extra++;
      end
      chk_i("en_off_frames", extra, 0);
      en = 1'b1;
      wait_frame("en_on", d, k);
      chk_w("en_on_frame", d, 16'h1777);
      chk_i("en_on_lat", k, 1);
      tick();

      // Reset in the middle of a held frame
      frame_ready = 1'b0;
      setch(5, 12'h0F0);
      wait_frame("midsend", d, k);
      chk_w("midsend_frame", d, 16'h50F0);
      tick();
      do_reset();
      frame_ready = 1'b1;
      startup_seq("restart");

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0)
            setch(int'($urandom_range(0, N_CH - 1)), DATA_W'($urandom_range(0, 3)));
         frame_ready = ($urandom_range(0, 9) < 7);
         en          = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 199) == 0) do_reset();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
